// File: rtl/id_regread_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_regread_scoreboard
// Purpose  : 32-entry integer register file with write-first read ports and
//            per-register pending counters that raise the ID RAW-hazard stall.
// Revision : 1.0  initial release
// ============================================================================
module id_regread_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we,
    input  logic [4:0]      wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            wb_retire,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_rd_we,
    input  logic            ex_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            stall,
    output logic            issue,
    output logic            pending_any,
    output logic            sb_err
);

    localparam int              AW        = 5;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [CNT_W-1:0] cnt_q  [NREGS];
    logic [CNT_W-1:0] cnt_d  [NREGS];
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] busy;
    logic             hz1;
    logic             hz2;
    logic             sat;
    logic             sb_err_q;
    logic             sb_err_d;
    logic             pending_any_q;
    logic             pending_any_d;

    // A retiring writer releases its register in the same cycle it retires.
    always_comb begin
        dec  = '0;
        busy = '0;
        for (int r = 0; r < NREGS; r++) begin
            dec[r]  = wb_retire && (wb_waddr == AW'(r)) && (r != 0);
            busy[r] = cnt_q[r] > {{(CNT_W-1){1'b0}}, dec[r]};
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (id_rs1_addr != '0) begin
            if (wb_we && (wb_waddr == id_rs1_addr)) rs1_data = wb_wdata;
            else                                    rs1_data = regs_q[id_rs1_addr];
        end
        if (id_rs2_addr != '0) begin
            if (wb_we && (wb_waddr == id_rs2_addr)) rs2_data = wb_wdata;
            else                                    rs2_data = regs_q[id_rs2_addr];
        end
    end

    always_comb begin
        hz1   = id_rs1_used && (id_rs1_addr != '0) && busy[id_rs1_addr];
        hz2   = id_rs2_used && (id_rs2_addr != '0) && busy[id_rs2_addr];
        sat   = id_rd_we && (id_rd_addr != '0) &&
                (cnt_q[id_rd_addr] == c_cnt_max) && !dec[id_rd_addr];
        stall = id_valid && (hz1 || hz2 || sat);
        issue = id_valid && !stall && ex_ready;
    end

    // Saturation stalls guarantee an increment never wraps a full counter.
    always_comb begin
        inc           = '0;
        sb_err_d      = sb_err_q;
        pending_any_d = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            inc[r]   = issue && id_rd_we && (id_rd_addr == AW'(r)) && (r != 0);
            cnt_d[r] = cnt_q[r];
            if (dec[r] && (cnt_q[r] == '0)) sb_err_d = 1'b1;
            if (inc[r] && !dec[r])
                cnt_d[r] = cnt_q[r] + 1'b1;
            else if (dec[r] && !inc[r] && (cnt_q[r] != '0))
                cnt_d[r] = cnt_q[r] - 1'b1;
            pending_any_d = pending_any_d | (cnt_d[r] != '0);

            regs_d[r] = regs_q[r];
            if (wb_we && (wb_waddr == AW'(r)) && (r != 0)) regs_d[r] = wb_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q      <= 1'b0;
            pending_any_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            sb_err_q      <= sb_err_d;
            pending_any_q <= pending_any_d;
        end
    end

    assign sb_err      = sb_err_q;
    assign pending_any = pending_any_q;

endmodule
`default_nettype wire

// File: doc/id_regread_scoreboard.md
Name: id_regread_scoreboard

Overview:
- Decode-side counterpart of the writeback path. Holds the 32x32 integer register file.
- Accepts the single writeback port from WB and serves two combinational read ports (rs1/rs2) to ID, with write-first bypass.
- Tracks in-flight destination registers with per-register pending counters and raises a RAW-hazard stall so ID never issues on stale operands.

Parameters:
- XLEN, 32, register data width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- CNT_W, 2, pending-counter width; at most 2^CNT_W-1 writers of one register may be in flight.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_we  in  1  WB writes wb_wdata to register wb_waddr this cycle.
- wb_waddr  in  5  WB destination register (instruction[11:7] at WB).
- wb_wdata  in  XLEN  WB write data (the selected writeback value).
- wb_retire  in  1  an instruction that was issued with id_rd_we=1 reaches WB this cycle. Asserted even if the instruction was squashed (wb_we=0 in that case).
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_addr  in  5  source register 1.
- id_rs2_addr  in  5  source register 2.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd_addr  in  5  destination register.
- id_rd_we  in  1  instruction writes rd.
- ex_ready  in  1  EX can accept an instruction this cycle.
- rs1_data  out  XLEN  operand 1.
- rs2_data  out  XLEN  operand 2.
- stall  out  1  RAW or counter-saturation hazard; ID must hold.
- issue  out  1  instruction handed to EX this cycle.
- pending_any  out  1  any pending counter nonzero (registered).
- sb_err  out  1  sticky: retire seen with counter already 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers and all counters clear to 0.
  - pending_any=0, sb_err=0.
  - Combinational outputs follow from the cleared state.
  - Reset mid-operation discards all in-flight tracking.
- Register write:
  - On the clock edge, if wb_we=1 and wb_waddr!=0, reg[wb_waddr] is updated with wb_wdata.
  - Writes to x0 are ignored.
- Read (combinational, zero latency), per port:
  - Address 0 returns 0.
  - Otherwise, if wb_we=1 and wb_waddr equals the read address, returns wb_wdata (write-first bypass).
  - Otherwise returns reg[addr].
- Effective busy, per register r:
  - busy(r) = (cnt[r] - dec(r)) != 0, where dec(r) = wb_retire and wb_waddr==r and r!=0.
  - A retire this cycle therefore clears the hazard in the same cycle.
- Stall: stall = id_valid and (hz1 or hz2 or sat), where:
  - hz1 = id_rs1_used and id_rs1_addr!=0 and busy(id_rs1_addr).
  - hz2 is the same for rs2.
  - sat = id_rd_we and id_rd_addr!=0 and cnt[id_rd_addr]==max and not dec(id_rd_addr).
- Issue: issue = id_valid and not stall and ex_ready.
- Counter update at each edge:
  - cnt[r] += inc(r) - dec(r), where inc(r) = issue and id_rd_we and id_rd_addr==r and r!=0.
  - Simultaneous inc and dec on the same register leaves it unchanged.
  - Decrement at 0 saturates at 0 and sets sb_err (cleared only by reset).
  - x0 never counts.
- pending_any is registered: the OR of the next-state counters.
- No bypass from EX/MEM results in this block. Forwarding, if added, lives elsewhere; stall is conservative.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> rs1_data=0, rs2_data=0, stall=0, pending_any=0; wb_we=1 to x0 with 0xDEAD, then read x0 -> 0.
- Issue rd=3 (id_rd_we=1, ex_ready=1), next cycle ID reads rs1=3 -> stall=1, issue=0. Then wb_retire=1, wb_we=1, waddr=3, wdata=0x12345678 in the same cycle -> stall=0, rs1_data=0x12345678; following cycle reg[3]=0x12345678 and cnt[3]=0.
- Issue rd=7 three times with no retire -> cnt[7]=3; a 4th issue to rd=7 -> stall=1 (sat). Assert wb_retire for x7 that cycle -> stall=0, issue=1, cnt[7] stays 3.
- Issue rd=4 and retire x4 in the same cycle with cnt[4]=1 -> cnt[4] remains 1, pending_any=1.
- Squashed writer: wb_retire=1, wb_we=0, waddr=9 with cnt[9]=1 -> cnt[9]=0, reg[9] unchanged. Extra retire to x9 -> cnt[9]=0 and sb_err=1 sticky.
- Assert rst_n=0 mid-cycle with cnt[3]=2 -> counters, registers and sb_err clear immediately; stall=0 without a clock edge.
